// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide beside the execute ALU.
// Define MULDIV_EARLY_OUT_EN to resolve div-by-zero/overflow without iterating.
module muldiv_sequencer #(
   parameter int DATA_WIDTH = 32,
   parameter int OP_WIDTH   = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  Start,
   input  logic                  Flush,
   input  logic [OP_WIDTH-1:0]   MulDivOp,
   input  logic [DATA_WIDTH-1:0] SrcA,
   input  logic [DATA_WIDTH-1:0] SrcB,
   output logic                  Busy,
   output logic                  Done,
   output logic [DATA_WIDTH-1:0] MulDivResult
);

   localparam int CW = $clog2(DATA_WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t state, state_nx;

   logic                    accept;
   logic                    wr_res;
   logic [CW-1:0]           cnt;
   logic [DATA_WIDTH-1:0]   opd;
   logic [DATA_WIDTH-1:0]   hi;
   logic [DATA_WIDTH-1:0]   lo;
   logic                    is_div;
   logic                    is_rem;
   logic                    is_low;
   logic                    neg_q;
   logic                    neg_r;
   logic                    bzero;

   logic                    sgn_a;
   logic                    sgn_b;
   logic                    a_neg;
   logic                    b_neg;
   logic                    b_zero;
   logic [DATA_WIDTH-1:0]   abs_a;
   logic [DATA_WIDTH-1:0]   abs_b;

   logic [DATA_WIDTH:0]     msum;
   logic [DATA_WIDTH:0]     dsh;
   logic                    dge;
   logic [DATA_WIDTH-1:0]   ddif;
   logic [DATA_WIDTH-1:0]   hi_nx;
   logic [DATA_WIDTH-1:0]   lo_nx;

   logic [2*DATA_WIDTH-1:0] pneg;
   logic [DATA_WIDTH-1:0]   q_fix;
   logic [DATA_WIDTH-1:0]   r_fix;
   logic [DATA_WIDTH-1:0]   fix_res;

`ifdef MULDIV_EARLY_OUT_EN
   logic                    ovf;
   logic                    early;

   assign ovf   = MulDivOp[2] & ~MulDivOp[0] &
                  (SrcA == {1'b1, {(DATA_WIDTH-1){1'b0}}}) & (&SrcB);
   assign early = MulDivOp[2] & (b_zero | ovf);
`endif

   always_comb begin
      sgn_a = 1'b0;
      sgn_b = 1'b0;
      unique case (MulDivOp[2:0])
         3'b001, 3'b100, 3'b110: begin
            sgn_a = 1'b1;
            sgn_b = 1'b1;
         end
         3'b010:  sgn_a = 1'b1;
         default: ;
      endcase
      a_neg  = sgn_a & SrcA[DATA_WIDTH-1];
      b_neg  = sgn_b & SrcB[DATA_WIDTH-1];
      abs_a  = a_neg ? -SrcA : SrcA;
      abs_b  = b_neg ? -SrcB : SrcB;
      b_zero = (SrcB == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      wr_res   = 1'b0;
      Busy     = 1'b0;
      Done     = 1'b0;
      unique case (state)
         IDLE: begin
            if (Start && !Flush) begin
               accept   = 1'b1;
               Busy     = 1'b1;
               state_nx = CALC;
`ifdef MULDIV_EARLY_OUT_EN
               if (early) state_nx = FIX;
`endif
            end
         end
         CALC: begin
            Busy = 1'b1;
            if (cnt == CW'(DATA_WIDTH-1)) state_nx = FIX;
         end
         FIX: begin
            Busy     = 1'b1;
            wr_res   = !Flush;
            state_nx = DONE;
         end
         DONE: begin
            Done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (Flush) state_nx = IDLE;
      if (rst) begin
         Busy = 1'b0;
         Done = 1'b0;
      end
   end

   // one radix-2 step: shift-add for multiply, restoring subtract for divide
   always_comb begin
      msum = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
      dsh  = {hi, lo[DATA_WIDTH-1]};
      dge  = (dsh >= {1'b0, opd});
      ddif = dsh[DATA_WIDTH-1:0] - opd;
      if (is_div) begin
         hi_nx = dge ? ddif : dsh[DATA_WIDTH-1:0];
         lo_nx = {lo[DATA_WIDTH-2:0], dge};
      end else begin
         hi_nx = msum[DATA_WIDTH:1];
         lo_nx = {msum[0], lo[DATA_WIDTH-1:1]};
      end
   end

   // a zero divisor leaves an all-ones quotient that must stay unsigned
   always_comb begin
      pneg  = neg_q ? -{hi, lo} : {hi, lo};
      q_fix = (neg_q && !bzero) ? -lo : lo;
      r_fix = neg_r ? -hi : hi;
      if (is_div)      fix_res = is_rem ? r_fix : q_fix;
      else if (is_low) fix_res = pneg[DATA_WIDTH-1:0];
      else             fix_res = pneg[2*DATA_WIDTH-1:DATA_WIDTH];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt          <= '0;
         MulDivResult <= '0;
      end else if (accept) begin
         cnt    <= '0;
         is_div <= MulDivOp[2];
         is_rem <= MulDivOp[2] & MulDivOp[1];
         is_low <= ~MulDivOp[2] & (MulDivOp[1:0] == 2'b00);
         neg_q  <= a_neg ^ b_neg;
         neg_r  <= a_neg;
         bzero  <= b_zero;
         hi     <= '0;
         if (MulDivOp[2]) begin
            opd <= abs_b;
            lo  <= abs_a;
         end else begin
            opd <= abs_a;
            lo  <= abs_b;
         end
`ifdef MULDIV_EARLY_OUT_EN
         if (MulDivOp[2] && b_zero) begin
            hi <= abs_a;
            lo <= '1;
         end else if (ovf) begin
            hi <= '0;
            lo <= abs_a;
         end
`endif
      end else if (state == CALC) begin
         cnt <= cnt + CW'(1);
         hi  <= hi_nx;
         lo  <= lo_nx;
      end else if (wr_res) begin
         MulDivResult <= fix_res;
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vectors with a queue scoreboard on Done.
module tb_muldiv_sequencer;

   localparam int DW = 32;
`ifdef MULDIV_EARLY_OUT_EN
   localparam int EO = 2;
`else
   localparam int EO = DW + 2;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          Start = 1'b0;
   logic          Flush = 1'b0;
   logic [2:0]    MulDivOp = '0;
   logic [DW-1:0] SrcA = '0;
   logic [DW-1:0] SrcB = '0;
   logic          Busy;
   logic          Done;
   logic [DW-1:0] MulDivResult;

   typedef struct {
      logic [DW-1:0] res;
      int            due;
      string         nm;
   } exp_t;

   typedef struct {
      logic [2:0]    op;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] exp;
      bit            sp;
      string         nm;
   } vec_t;

   exp_t          sb[$];
   vec_t          vecs[$];
   int            n_vec = 0;
   int            n_err = 0;
   int            cyc = 0;
   logic [DW-1:0] last_res = '0;

   muldiv_sequencer #(.DATA_WIDTH(DW), .OP_WIDTH(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .Start        (Start),
      .Flush        (Flush),
      .MulDivOp     (MulDivOp),
      .SrcA         (SrcA),
      .SrcB         (SrcB),
      .Busy         (Busy),
      .Done         (Done),
      .MulDivResult (MulDivResult)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (Done === 1'b1) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL spurious_done: got Done=1 at cycle %0d want none", cyc);
         end else begin
            e = sb.pop_front();
            chk({e.nm, "_res"}, MulDivResult, e.res);
            chk({e.nm, "_lat"}, cyc, e.due);
         end
      end
   end

   task automatic drain(string nm);
      int n = 0;
      #1;
      while (sb.size() != 0 && n < 60) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (sb.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s_timeout: got no Done in %0d cycles want Done", nm, n);
         sb.delete();
      end
   endtask

   task automatic issue(vec_t v);
      int lat;
      int nb;
      lat = v.sp ? EO : DW + 2;
      @(negedge clk);
      Start    = 1'b1;
      MulDivOp = v.op;
      SrcA     = v.a;
      SrcB     = v.b;
      #1 chk({v.nm, "_busy_acc"}, Busy, 1);
      sb.push_back('{res: v.exp, due: cyc + lat, nm: v.nm});
      @(posedge clk);
      #1;
      Start    = 1'b0;
      SrcA     = $urandom;
      SrcB     = $urandom;
      MulDivOp = 3'($urandom);
      nb = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (Busy) nb++;
         else break;
      end
      chk({v.nm, "_busy_len"}, nb, lat - 1);
      drain(v.nm);
      last_res = v.exp;
   endtask

   function automatic void add(logic [2:0] op, logic [DW-1:0] a,
                               logic [DW-1:0] b, logic [DW-1:0] exp,
                               bit sp, string nm);
      vecs.push_back('{op: op, a: a, b: b, exp: exp, sp: sp, nm: nm});
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1);
   end

   initial begin
      add(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0, "mul_neg");
      add(3'b000, 32'h12345678, 32'h10,       32'h23456780, 0, "mul_big");
      add(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 0, "mulh_min");
      add(3'b001, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 0, "mulh_neg");
      add(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        0, "mulh_m1");
      add(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, "mulhu");
      add(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "mulhsu");
      add(3'b010, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 0, "mulhsu2");
      add(3'b100, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 0, "div_neg");
      add(3'b110, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 0, "rem_neg");
      add(3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 0, "div_negb");
      add(3'b110, 32'd7,        32'hFFFFFFFE, 32'h1,        0, "rem_negb");
      add(3'b101, 32'd100,      32'd7,        32'd14,       0, "divu");
      add(3'b111, 32'd100,      32'd7,        32'd2,        0, "remu");
      add(3'b101, 32'h1234,     32'h0,        32'hFFFFFFFF, 1, "divu_z");
      add(3'b111, 32'h1234,     32'h0,        32'h1234,     1, "remu_z");
      add(3'b100, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFFF, 1, "div_z");
      add(3'b110, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 1, "rem_z");
      add(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf");
      add(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1, "rem_ovf");

      Start = 1'b1;
      @(negedge clk);
      chk("rst_busy", Busy, 0);
      chk("rst_done", Done, 0);
      @(posedge clk);
      #1;
      rst   = 1'b0;
      Start = 1'b0;
      chk("rst_res", MulDivResult, 0);
      chk("rst_done2", Done, 0);

      foreach (vecs[i]) issue(vecs[i]);

      // flush ten cycles into a multiply, then restart right away
      @(negedge clk);
      Start    = 1'b1;
      MulDivOp = 3'b000;
      SrcA     = 32'd5;
      SrcB     = 32'd6;
      @(posedge clk);
      #1 Start = 1'b0;
      repeat (9) @(negedge clk);
      Flush = 1'b1;
      @(posedge clk);
      #1 Flush = 1'b0;
      chk("flush_busy", Busy, 0);
      chk("flush_res", MulDivResult, last_res);
      issue('{op: 3'b101, a: 32'd1000, b: 32'd9, exp: 32'd111,
              sp: 0, nm: "after_flush"});

      @(negedge clk);
      Start    = 1'b1;
      Flush    = 1'b1;
      MulDivOp = 3'b101;
      SrcA     = 32'd100;
      SrcB     = 32'd7;
      #1 chk("sf_busy", Busy, 0);
      @(posedge clk);
      #1;
      Start = 1'b0;
      Flush = 1'b0;
      chk("sf_idle", Busy, 0);
      repeat (40) @(negedge clk);
      chk("sf_res", MulDivResult, last_res);

      fork
         issue('{op: 3'b000, a: 32'd9, b: 32'd11, exp: 32'd99,
                 sp: 0, nm: "restart_ign"});
         begin
            repeat (6) @(negedge clk);
            Start    = 1'b1;
            MulDivOp = 3'b100;
            SrcA     = 32'd50;
            SrcB     = 32'd5;
            @(negedge clk);
            Start = 1'b0;
         end
      join

      @(negedge clk);
      Start    = 1'b1;
      MulDivOp = 3'b001;
      SrcA     = 32'h0000F00D;
      SrcB     = 32'h00BEEF00;
      @(posedge clk);
      #1 Start = 1'b0;
      repeat (19) @(negedge clk);
      rst = 1'b1;
      #1 chk("midrst_busy", Busy, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("midrst_res", MulDivResult, 0);
      chk("midrst_done", Done, 0);
      chk("midrst_idle", Busy, 0);
      repeat (40) @(negedge clk);
      chk("midrst_res2", MulDivResult, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
